// File: rtl/z16_mem_arbiter.sv
// rtl/z16_mem_arbiter.sv - two-port (fetch/data) arbiter for a single synchronous-read memory
module z16_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic              o_d_rvalid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  // Counter is 4 bits wide so any MAX_WAIT in 1..15 fits.
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       if_rd;
  logic       d_rd;
  logic       force_if;

  // Grant decision: data wins by default, fetch wins once it has been denied MAX_WAIT times in a row.
  always_comb begin
    force_if = i_if_req && (wait_cnt == WAIT_MAX);
    o_if_ack = !i_rst && i_if_req && (!i_d_req || force_if);
    o_d_ack  = !i_rst && i_d_req && !o_if_ack;
  end

  // Memory command mux; all fields are forced to zero when nothing is granted.
  always_comb begin
    o_mem_en    = o_if_ack | o_d_ack;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_if_ack) begin
      o_mem_addr = i_if_addr;
    end else if (o_d_ack) begin
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
    end
  end

  // Starvation counter and read tag that steers the returning memory data to its requester.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
      if_rd    <= 1'b0;
      d_rd     <= 1'b0;
    end else begin
      if_rd <= o_if_ack;
      d_rd  <= o_d_ack & ~i_d_we;
      if (!i_if_req || o_if_ack) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Read returns; gating with reset kills a read tagged in the cycle just before reset.
  always_comb begin
    o_if_rvalid = if_rd & ~i_rst;
    o_d_rvalid  = d_rd & ~i_rst;
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;
  end

endmodule
